cla_mp_sequencer: RTL and testbench

//   Multi-precision adder sequencer. Accepts one wide add request (A + B + Cin) through a

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla8_slice.sv | 39 +++
 rtl/cla_mp_sequencer.sv | 112 +++++++++++
 tb/tb_cla_mp_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA sequencer.
// Covers the datapath slice width and the FSM state encoding.
package cla_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
// Every carry is a flat sum of generate/propagate products rather than a ripple chain.
module cla8_slice
  import cla_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   carry;
  logic              pterm;

  // Carry into bit i+1 is g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    pterm    = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      carry[i+1] = gen[i];
      pterm      = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (pterm & gen[j]);
        pterm      = pterm & prop[j];
      end
      carry[i+1] = carry[i+1] | (pterm & cin);
    end
  end

  assign sum  = prop ^ carry[BYTE_W-1:0];
  assign cout = carry[BYTE_W];

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision adder: runs one wide A+B+Cin through a single 8-bit CLA,
// one byte per cycle LSB first, and returns the registered sum and carry-out.
module cla_mp_sequencer
  import cla_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NWORDS-1:0] in_a,
  input  logic [BYTE_W*NWORDS-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NWORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int W    = BYTE_W * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t state, state_nxt;

  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [IDXW-1:0]   idx;
  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_sum;
  logic              slice_cout;
  logic              last_byte;

  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_byte) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  // Constant-index byte mux keeps every select in range for any NWORDS.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx == IDXW'(k)) begin
        slice_a = a_q[k*BYTE_W +: BYTE_W];
        slice_b = b_q[k*BYTE_W +: BYTE_W];
      end
    end
  end

  cla8_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        a_q     <= in_a;
        b_q     <= in_b;
        carry_q <= in_cin;
        idx     <= '0;
      end
    end else if (state == ST_RUN) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (idx == IDXW'(k)) sum_q[k*BYTE_W +: BYTE_W] <= slice_sum;
      end
      carry_q <= slice_cout;
      // idx parks on the last byte so it never wraps.
      if (last_byte) cout_q <= slice_cout;
      else           idx    <= idx + IDXW'(1);
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer: a 4-byte instance driven from a vector table
// plus backpressure/reset sequences, and a 1-byte instance for the single-slice case.
module tb_cla_mp_sequencer;
  import cla_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv4, ir4, ov4, or4, cin4, cout4, busy4;
  logic [31:0] a4, b4, sum4;
  logic        iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [9];

  cla_mp_sequencer #(.NWORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_cin(cin4), .out_valid(ov4), .out_ready(or4), .out_sum(sum4), .out_cout(cout4),
    .busy(busy4)
  );

  cla_mp_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_cin(cin1), .out_valid(ov1), .out_ready(or1), .out_sum(sum1), .out_cout(cout1),
    .busy(busy1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Issues one op and waits (bounded) for out_valid; lat counts edges from the accept edge.
  task automatic applyStimulus(input bit narrow, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic ordy,
                               output logic [31:0] s, output logic c, output int lat);
    logic v;
    if (narrow) begin
      a1 = a[7:0]; b1 = b[7:0]; cin1 = cin; or1 = ordy; iv1 = 1'b1;
      checkOutput("in_ready_before_accept_n1", {63'd0, ir1}, 64'd1);
    end else begin
      a4 = a; b4 = b; cin4 = cin; or4 = ordy; iv4 = 1'b1;
      checkOutput("in_ready_before_accept_n4", {63'd0, ir4}, 64'd1);
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
    lat = 1;
    v = narrow ? ov1 : ov4;
    while (!v && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      v = narrow ? ov1 : ov4;
    end
    s = narrow ? {24'h0, sum1} : sum4;
    c = narrow ? cout1 : cout4;
    checkOutput("out_valid_seen", {63'd0, v}, 64'd1);
    if (ordy) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] s;
    logic        c;
    int          lat;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[1] = '{32'd24,        32'd1,         1'b1, 32'd26,        1'b0};
    vecs[2] = '{32'd5,         32'd7,         1'b0, 32'd12,        1'b0};
    vecs[3] = '{32'd9,         32'd9,         1'b1, 32'd19,        1'b0};
    vecs[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  {63'd0, ir4},   64'd1);
    checkOutput("reset_out_valid", {63'd0, ov4},   64'd0);
    checkOutput("reset_out_sum",   {32'd0, sum4},  64'd0);
    checkOutput("reset_out_cout",  {63'd0, cout4}, 64'd0);
    checkOutput("reset_busy",      {63'd0, busy4}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, s, c, lat);
      checkOutput($sformatf("vec%0d_sum", i),  {32'd0, s},  {32'd0, vecs[i].sum});
      checkOutput($sformatf("vec%0d_cout", i), {63'd0, c},  {63'd0, vecs[i].cout});
      checkOutput($sformatf("vec%0d_lat", i),  64'(lat),    64'd5);
    end

    // Backpressure: result must hold and further requests must be refused.
    applyStimulus(1'b0, 32'd1, 32'd2, 1'b0, 1'b0, s, c, lat);
    checkOutput("bp_first_sum", {32'd0, s}, 64'd3);
    for (int k = 0; k < 7; k++) begin
      a4 = 32'hDEAD_BEEF; b4 = 32'h1111_1111; cin4 = 1'b1; iv4 = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_out_valid", k), {63'd0, ov4},   64'd1);
      checkOutput($sformatf("bp%0d_sum", k),       {32'd0, sum4},  64'd3);
      checkOutput($sformatf("bp%0d_cout", k),      {63'd0, cout4}, 64'd0);
      checkOutput($sformatf("bp%0d_in_ready", k),  {63'd0, ir4},   64'd0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_out_valid", {63'd0, ov4},   64'd0);
    checkOutput("bp_release_in_ready",  {63'd0, ir4},   64'd1);
    checkOutput("bp_release_busy",      {63'd0, busy4}, 64'd0);
    applyStimulus(1'b0, 32'h10, 32'h20, 1'b1, 1'b1, s, c, lat);
    checkOutput("b2b_sum",  {32'd0, s}, 64'h31);
    checkOutput("b2b_cout", {63'd0, c}, 64'd0);
    checkOutput("b2b_lat",  64'(lat),   64'd5);

    // Asynchronous abort two cycles into an op.
    a4 = 32'h0000_00FF; b4 = 32'd1; cin4 = 1'b0; or4 = 1'b1; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_busy_before", {63'd0, busy4}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", {63'd0, ov4},   64'd0);
    checkOutput("abort_busy",      {63'd0, busy4}, 64'd0);
    checkOutput("abort_in_ready",  {63'd0, ir4},   64'd1);
    checkOutput("abort_out_sum",   {32'd0, sum4},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_idle_out_valid", {63'd0, ov4}, 64'd0);
    applyStimulus(1'b0, 32'd1, 32'd1, 1'b0, 1'b1, s, c, lat);
    checkOutput("post_abort_sum",  {32'd0, s}, 64'd2);
    checkOutput("post_abort_cout", {63'd0, c}, 64'd0);

    // Single-slice instance.
    applyStimulus(1'b1, 32'h00, 32'h00, 1'b1, 1'b1, s, c, lat);
    checkOutput("n1_zero_sum",  {32'd0, s}, 64'h01);
    checkOutput("n1_zero_cout", {63'd0, c}, 64'd0);
    checkOutput("n1_zero_lat",  64'(lat),   64'd2);
    applyStimulus(1'b1, 32'hFF, 32'h00, 1'b1, 1'b1, s, c, lat);
    checkOutput("n1_ff_sum",  {32'd0, s}, 64'h00);
    checkOutput("n1_ff_cout", {63'd0, c}, 64'd1);
    applyStimulus(1'b1, 32'hFF, 32'hFF, 1'b1, 1'b1, s, c, lat);
    checkOutput("n1_ffff_sum",  {32'd0, s}, 64'hFF);
    checkOutput("n1_ffff_cout", {63'd0, c}, 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
